// File: rtl/riscv_types.sv
// Shared types for the core pipeline control path: sequencer states, the
// packed enable/clear bundle and the hazard priority helper.
package riscv_types;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2,
      STEP   = 2'd3
   } ctrl_state_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_exe_en;
      logic exe_mem_en;
      logic mem_wb_en;
      logic if_id_clr;
      logic id_exe_clr;
      logic exe_mem_clr;
      logic mem_wb_clr;
   } pipe_ctrl_t;

   localparam int WAIT_W  = 8;  // holds MAX_WAIT up to 255
   localparam int DRAIN_W = 4;  // holds DRAIN_CYCLES up to 15

   // Free-running pipeline: everything advances, nothing is flushed.
   localparam pipe_ctrl_t CTRL_RUN   = 9'b11111_0000;
   // Reset: everything frozen and flushed.
   localparam pipe_ctrl_t CTRL_RESET = 9'b00000_1111;
   // Halted: frozen, contents kept.
   localparam pipe_ctrl_t CTRL_IDLE  = 9'b00000_0000;

   // Bus wait beats a redirect, which beats a load-use stall.
   function automatic pipe_ctrl_t apply_hazards(input pipe_ctrl_t base,
                                                input logic       busy,
                                                input logic       redirect,
                                                input logic       load_use);
      pipe_ctrl_t c;
      c = base;
      if (busy) begin
         c.pc_en       = 1'b0;
         c.if_id_en    = 1'b0;
         c.id_exe_en   = 1'b0;
         c.exe_mem_en  = 1'b0;
         c.if_id_clr   = 1'b0;
         c.id_exe_clr  = 1'b0;
         c.exe_mem_clr = 1'b0;
         c.mem_wb_clr  = 1'b1;
      end else if (redirect) begin
         c.pc_en       = 1'b1;
         c.if_id_clr   = 1'b1;
         c.id_exe_clr  = 1'b1;
         c.exe_mem_clr = 1'b1;
      end else if (load_use) begin
         c.pc_en       = 1'b0;
         c.if_id_en    = 1'b0;
         c.id_exe_clr  = 1'b1;
      end else begin
         c = base;
      end
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard detection: load-use dependency between EXE and ID,
// and data-bus wait state with a bounded wait before forced release.
module hazard_detect
   import riscv_types::*;
#(
   parameter int MAX_WAIT = 255
) (
   input  logic [4:0]        rs1_id_i,
   input  logic [4:0]        rs2_id_i,
   input  logic [4:0]        rd_exe_i,
   input  logic              mem_to_reg_exe_i,
   input  logic              mem_write_mem_i,
   input  logic              mem_to_reg_mem_i,
   input  logic              mem_ready_i,
   input  logic [WAIT_W-1:0] wait_cnt_i,
   output logic              load_use_o,
   output logic              mem_busy_o,
   output logic              wait_expired_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic mem_stuck_s;

   // An access is stuck whenever MEM holds a load/store the bus has not completed.
   assign mem_stuck_s = (mem_write_mem_i | mem_to_reg_mem_i) & ~mem_ready_i;

   // Classify hazards; once the wait budget is used up the access is let go.
   always_comb begin
      load_use_o     = mem_to_reg_exe_i & (rd_exe_i != 5'd0) &
                       ((rd_exe_i == rs1_id_i) | (rd_exe_i == rs2_id_i));
      mem_busy_o     = mem_stuck_s & (wait_cnt_i <  MAX_WAIT_C);
      wait_expired_o = mem_stuck_s & (wait_cnt_i == MAX_WAIT_C);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: drives every pipeline-register enable/clear,
// runs the halt/drain/single-step debug FSM and counts front-end stalls.
module pipeline_ctrl
   import riscv_types::*;
#(
   parameter int DRAIN_CYCLES = 4,
   parameter int MAX_WAIT     = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic [4:0]       rd_exe,
   input  logic             mem_to_reg_exe,
   input  logic             pc_sel_mem,
   input  logic             mem_write_mem,
   input  logic             mem_to_reg_mem,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             step_req,
   output logic             pc_reg_en,
   output logic             if_id_reg_en,
   output logic             id_exe_reg_en,
   output logic             exe_mem_reg_en,
   output logic             mem_wb_reg_en,
   output logic             if_id_reg_clr,
   output logic             id_exe_reg_clr,
   output logic             exe_mem_reg_clr,
   output logic             mem_wb_reg_clr,
   output logic             halted,
   output logic             bus_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_state_t        state_q, state_d;
   logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               halted_q, bus_timeout_q;
   logic               load_use_s, mem_busy_s, wait_expired_s;
   pipe_ctrl_t         ctrl_s;

   hazard_detect #(.MAX_WAIT(MAX_WAIT)) u_hazard (
      .rs1_id_i         (rs1_id),
      .rs2_id_i         (rs2_id),
      .rd_exe_i         (rd_exe),
      .mem_to_reg_exe_i (mem_to_reg_exe),
      .mem_write_mem_i  (mem_write_mem),
      .mem_to_reg_mem_i (mem_to_reg_mem),
      .mem_ready_i      (mem_ready),
      .wait_cnt_i       (wait_cnt_q),
      .load_use_o       (load_use_s),
      .mem_busy_o       (mem_busy_s),
      .wait_expired_o   (wait_expired_s)
   );

   // Next-state and pipeline control; reset forces a full freeze-and-flush.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      ctrl_s      = CTRL_RUN;
      if (reset) begin
         ctrl_s = CTRL_RESET;
      end else begin
         case (state_q)
            RUN: begin
               ctrl_s = apply_hazards(CTRL_RUN, mem_busy_s, pc_sel_mem, load_use_s);
               if (halt_req && !mem_busy_s) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
               end else begin
                  state_d = RUN;
               end
            end
            STEP: begin
               ctrl_s      = apply_hazards(CTRL_RUN, mem_busy_s, pc_sel_mem, load_use_s);
               state_d     = DRAIN;
               drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
            end
            DRAIN: begin
               // Load-use is moot here: the ID instruction is being flushed anyway.
               ctrl_s           = apply_hazards(CTRL_RUN, mem_busy_s, pc_sel_mem, 1'b0);
               ctrl_s.if_id_clr = 1'b1;
               // A redirect still captures its target so resume fetches the right PC.
               ctrl_s.pc_en     = !mem_busy_s && pc_sel_mem;
               if (!mem_busy_s) begin
                  if (drain_cnt_q == 4'd1) begin
                     state_d     = HALTED;
                     drain_cnt_d = 4'd0;
                  end else begin
                     drain_cnt_d = drain_cnt_q - 4'd1;
                  end
               end else begin
                  drain_cnt_d = drain_cnt_q;
               end
            end
            HALTED: begin
               ctrl_s = CTRL_IDLE;
               if (!halt_req) begin
                  state_d = RUN;
               end else if (step_req) begin
                  state_d = STEP;
               end else begin
                  state_d = HALTED;
               end
            end
            default: begin
               ctrl_s  = CTRL_RESET;
               state_d = RUN;
            end
         endcase
      end
   end

   // Wait-state tracking and saturating stall counter.
   always_comb begin
      wait_cnt_d = mem_busy_s ? (wait_cnt_q + 8'd1) : 8'd0;
      if ((state_q == RUN) && !ctrl_s.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         drain_cnt_q   <= 4'd0;
         wait_cnt_q    <= 8'd0;
         stall_cnt_q   <= {CNT_W{1'b0}};
         halted_q      <= 1'b0;
         bus_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         halted_q      <= (state_d == HALTED);
         bus_timeout_q <= wait_expired_s;
      end
   end

   assign pc_reg_en       = ctrl_s.pc_en;
   assign if_id_reg_en    = ctrl_s.if_id_en;
   assign id_exe_reg_en   = ctrl_s.id_exe_en;
   assign exe_mem_reg_en  = ctrl_s.exe_mem_en;
   assign mem_wb_reg_en   = ctrl_s.mem_wb_en;
   assign if_id_reg_clr   = ctrl_s.if_id_clr;
   assign id_exe_reg_clr  = ctrl_s.id_exe_clr;
   assign exe_mem_reg_clr = ctrl_s.exe_mem_clr;
   assign mem_wb_reg_clr  = ctrl_s.mem_wb_clr;
   assign halted          = halted_q;
   assign bus_timeout     = bus_timeout_q;
   assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with DRAIN_CYCLES=4, MAX_WAIT=4, CNT_W=4.
module tb_pipeline_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] rs1_id, rs2_id, rd_exe;
   logic       mem_to_reg_exe, pc_sel_mem, mem_write_mem, mem_to_reg_mem, mem_ready;
   logic       halt_req, step_req;
   logic       pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en;
   logic       if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr;
   logic       halted, bus_timeout;
   logic [3:0] stall_cnt;
   logic [8:0] ctrl_obs;

   int checks   = 0;
   int failures = 0;

   // Expected control patterns {pc,if_id,id_exe,exe_mem,mem_wb en | if_id,id_exe,exe_mem,mem_wb clr}
   localparam logic [8:0] C_RUN   = 9'b11111_0000;
   localparam logic [8:0] C_RST   = 9'b00000_1111;
   localparam logic [8:0] C_IDLE  = 9'b00000_0000;
   localparam logic [8:0] C_LU    = 9'b00111_0100;
   localparam logic [8:0] C_REDIR = 9'b11111_1110;
   localparam logic [8:0] C_BUSY  = 9'b00001_0001;
   localparam logic [8:0] C_DRAIN = 9'b01111_1000;

   pipeline_ctrl #(.DRAIN_CYCLES(4), .MAX_WAIT(4), .CNT_W(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .rs1_id          (rs1_id),
      .rs2_id          (rs2_id),
      .rd_exe          (rd_exe),
      .mem_to_reg_exe  (mem_to_reg_exe),
      .pc_sel_mem      (pc_sel_mem),
      .mem_write_mem   (mem_write_mem),
      .mem_to_reg_mem  (mem_to_reg_mem),
      .mem_ready       (mem_ready),
      .halt_req        (halt_req),
      .step_req        (step_req),
      .pc_reg_en       (pc_reg_en),
      .if_id_reg_en    (if_id_reg_en),
      .id_exe_reg_en   (id_exe_reg_en),
      .exe_mem_reg_en  (exe_mem_reg_en),
      .mem_wb_reg_en   (mem_wb_reg_en),
      .if_id_reg_clr   (if_id_reg_clr),
      .id_exe_reg_clr  (id_exe_reg_clr),
      .exe_mem_reg_clr (exe_mem_reg_clr),
      .mem_wb_reg_clr  (mem_wb_reg_clr),
      .halted          (halted),
      .bus_timeout     (bus_timeout),
      .stall_cnt       (stall_cnt)
   );

   assign ctrl_obs = {pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en,
                      if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr};

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs1_id = 5'd0; rs2_id = 5'd0; rd_exe = 5'd0;
      mem_to_reg_exe = 1'b0; pc_sel_mem = 1'b0;
      mem_write_mem = 1'b0; mem_to_reg_mem = 1'b0; mem_ready = 1'b1;
      step_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; halt_req = 1'b0;
      idle_inputs();
      #2;
      chk("reset_ctrl", ctrl_obs, C_RST);
      chk("reset_halted", {8'd0, halted}, 9'd0);
      chk("reset_timeout", {8'd0, bus_timeout}, 9'd0);
      chk("reset_stall", {5'd0, stall_cnt}, 9'd0);
      tick();
      reset = 1'b0;

      // Plain run
      tick(); idle_inputs(); #1;
      chk("run_ctrl", ctrl_obs, C_RUN);

      // Load-use on rs1: one stall cycle
      tick(); rd_exe = 5'd5; mem_to_reg_exe = 1'b1; rs1_id = 5'd5; #1;
      chk("lu_ctrl", ctrl_obs, C_LU);
      tick(); idle_inputs(); #1;
      chk("lu_after_ctrl", ctrl_obs, C_RUN);
      chk("lu_stall_cnt", {5'd0, stall_cnt}, 9'd1);

      // Load to x0 never stalls
      tick(); rd_exe = 5'd0; mem_to_reg_exe = 1'b1; rs1_id = 5'd0; #1;
      chk("lu_x0_ctrl", ctrl_obs, C_RUN);
      tick(); idle_inputs(); #1;
      chk("lu_x0_stall", {5'd0, stall_cnt}, 9'd1);

      // Redirect outranks load-use
      tick(); rd_exe = 5'd7; mem_to_reg_exe = 1'b1; rs2_id = 5'd7; pc_sel_mem = 1'b1; #1;
      chk("redir_ctrl", ctrl_obs, C_REDIR);
      tick(); idle_inputs(); #1;
      chk("redir_stall", {5'd0, stall_cnt}, 9'd1);

      // Three wait states, released by mem_ready on the fourth cycle
      for (int i = 0; i < 3; i++) begin
         tick(); mem_to_reg_mem = 1'b1; mem_ready = 1'b0; #1;
         chk("wait_freeze", ctrl_obs, C_BUSY);
      end
      tick(); mem_ready = 1'b1; #1;
      chk("wait_release", ctrl_obs, C_RUN);
      tick(); idle_inputs(); #1;
      chk("wait_no_timeout", {8'd0, bus_timeout}, 9'd0);
      chk("wait_stall", {5'd0, stall_cnt}, 9'd4);

      // Timeout: four frozen cycles, forced release on the fifth
      for (int i = 0; i < 4; i++) begin
         tick(); mem_to_reg_mem = 1'b1; mem_ready = 1'b0; #1;
         chk("to_freeze", ctrl_obs, C_BUSY);
         chk("to_no_pulse_yet", {8'd0, bus_timeout}, 9'd0);
      end
      tick(); #1;
      chk("to_release", ctrl_obs, C_RUN);
      chk("to_pulse_late", {8'd0, bus_timeout}, 9'd0);
      // New stuck store: freezes again only if the wait counter cleared
      tick(); mem_to_reg_mem = 1'b0; mem_write_mem = 1'b1; #1;
      chk("to_pulse", {8'd0, bus_timeout}, 9'd1);
      chk("to_wait_cleared", ctrl_obs, C_BUSY);
      tick(); mem_ready = 1'b1; #1;
      chk("to_pulse_end", {8'd0, bus_timeout}, 9'd0);
      chk("to_after_ctrl", ctrl_obs, C_RUN);
      tick(); idle_inputs(); #1;
      chk("to_stall", {5'd0, stall_cnt}, 9'd9);

      // Saturation: 8 more stall cycles from 9 would wrap to 1
      for (int i = 0; i < 8; i++) begin
         tick(); rd_exe = 5'd3; mem_to_reg_exe = 1'b1; rs2_id = 5'd3; #1;
      end
      tick(); idle_inputs(); #1;
      chk("stall_saturate", {5'd0, stall_cnt}, 9'd15);

      // Reset asserted in the second DRAIN cycle
      tick(); halt_req = 1'b1; #1;
      chk("rd_enter", ctrl_obs, C_RUN);
      tick(); #1;
      chk("rd_drain1", ctrl_obs, C_DRAIN);
      tick(); #1;
      chk("rd_drain2", ctrl_obs, C_DRAIN);
      reset = 1'b1; #1;
      chk("rd_reset_ctrl", ctrl_obs, C_RST);
      chk("rd_reset_stall", {5'd0, stall_cnt}, 9'd0);
      tick();
      chk("rd_reset_hold", ctrl_obs, C_RST);
      halt_req = 1'b0;
      reset = 1'b0;
      tick(); #1;
      chk("rd_run_ctrl", ctrl_obs, C_RUN);
      chk("rd_run_halted", {8'd0, halted}, 9'd0);
      chk("rd_run_stall", {5'd0, stall_cnt}, 9'd0);

      // Halt: four drain cycles, load-use ignored, redirect honoured
      tick(); halt_req = 1'b1; #1;
      chk("h_enter", ctrl_obs, C_RUN);
      tick(); #1;
      chk("h_d1", ctrl_obs, C_DRAIN);
      chk("h_d1_halted", {8'd0, halted}, 9'd0);
      tick(); rd_exe = 5'd9; mem_to_reg_exe = 1'b1; rs1_id = 5'd9; #1;
      chk("h_d2_lu_ignored", ctrl_obs, C_DRAIN);
      tick(); idle_inputs(); pc_sel_mem = 1'b1; #1;
      chk("h_d3_redirect", ctrl_obs, C_REDIR);
      tick(); idle_inputs(); #1;
      chk("h_d4", ctrl_obs, C_DRAIN);
      chk("h_d4_halted", {8'd0, halted}, 9'd0);
      tick(); #1;
      chk("h_halted", {8'd0, halted}, 9'd1);
      chk("h_halted_ctrl", ctrl_obs, C_IDLE);
      tick(); #1;
      chk("h_hold", {8'd0, halted}, 9'd1);

      // Single step
      step_req = 1'b1; #1;
      chk("s_req_ctrl", ctrl_obs, C_IDLE);
      tick(); step_req = 1'b0; #1;
      chk("s_step_ctrl", ctrl_obs, C_RUN);
      chk("s_step_halted", {8'd0, halted}, 9'd0);
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("s_drain", ctrl_obs, C_DRAIN);
         chk("s_drain_halted", {8'd0, halted}, 9'd0);
      end
      tick(); #1;
      chk("s_rehalted", {8'd0, halted}, 9'd1);
      chk("s_rehalted_ctrl", ctrl_obs, C_IDLE);

      // Resume wins over a simultaneous step
      halt_req = 1'b0; step_req = 1'b1; #1;
      chk("r_req_halted", {8'd0, halted}, 9'd1);
      tick(); step_req = 1'b0; #1;
      chk("r_run_ctrl", ctrl_obs, C_RUN);
      chk("r_halted_drop", {8'd0, halted}, 9'd0);
      chk("r_stall_untouched", {5'd0, stall_cnt}, 9'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
